// File: rtl/start_gen_pkg.sv
// Shared types and default timing for the start level generator.
package start_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } start_gen_state_t;

    localparam int HOLD_DEFAULT_DEF = 3;
    localparam int GAP_CYCLES_DEF   = 2;

endpackage

// File: rtl/start_level_generator_if.sv
// Request/level bus between the start requester and the start level generator.
interface start_level_generator_if #(
    parameter int CNT_W = 8
);
    logic             start_req;
    logic [CNT_W-1:0] hold_cycles;
    logic             startData;
    logic             busy;
    logic             pending;
    logic             done;
    logic             overflow;

    // start_req is a per-cycle request strobe with no back-pressure: every high
    // cycle is a request; it is started, queued (depth one) or dropped with overflow.
    modport master (
        output start_req, hold_cycles,
        input  startData, busy, pending, done, overflow
    );

    modport slave (
        input  start_req, hold_cycles,
        output startData, busy, pending, done, overflow
    );
endinterface

// File: rtl/start_gen_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module start_gen_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/start_level_generator.sv
// Turns one-cycle start requests into a startData level: len cycles high, then a
// guaranteed low gap, with a single-entry queue for requests arriving while busy.
module start_level_generator
    import start_gen_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int HOLD_DEFAULT = HOLD_DEFAULT_DEF,
    parameter int GAP_CYCLES   = GAP_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     n_rst,
    start_level_generator_if.slave   bus,
    output start_gen_state_t         dbg_state
);

    localparam logic [CNT_W-1:0] HOLD_LEN = CNT_W'(HOLD_DEFAULT);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    start_gen_state_t state;
    logic [CNT_W-1:0] qlen;
    logic [CNT_W-1:0] req_len;
    logic             cnt_zero;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_en;
    logic             gap_exit;
    logic             queue_req;

    assign req_len  = (bus.hold_cycles == '0) ? HOLD_LEN : bus.hold_cycles;
    assign gap_exit = (state == GAP) && cnt_zero;
    // Requests while busy go to the queue, except on the gap-exit edge where the
    // FSM itself decides between serving and re-queueing.
    assign queue_req = bus.start_req && (state != IDLE) && !gap_exit;

    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_req) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = req_len - CNT_W'(1);
                end
            end
            HIGH: begin
                if (cnt_zero) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = GAP_LOAD;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    if (bus.pending) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = qlen - CNT_W'(1);
                    end else if (bus.start_req) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = req_len - CNT_W'(1);
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    start_gen_counter #(.CNT_W(CNT_W)) u_counter (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state         <= IDLE;
            qlen          <= '0;
            bus.startData <= 1'b0;
            bus.busy      <= 1'b0;
            bus.pending   <= 1'b0;
            bus.done      <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            bus.done     <= 1'b0;
            bus.overflow <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_req) begin
                        state         <= HIGH;
                        bus.startData <= 1'b1;
                        bus.busy      <= 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt_zero) begin
                        state         <= GAP;
                        bus.startData <= 1'b0;
                    end
                end
                GAP: begin
                    if (cnt_zero) begin
                        bus.done <= 1'b1;
                        if (bus.pending) begin
                            // Serve the queued length; a same-cycle request takes its slot.
                            state         <= HIGH;
                            bus.startData <= 1'b1;
                            bus.pending   <= bus.start_req;
                            if (bus.start_req) begin
                                qlen <= req_len;
                            end
                        end else if (bus.start_req) begin
                            state         <= HIGH;
                            bus.startData <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.startData <= 1'b0;
                    bus.busy      <= 1'b0;
                end
            endcase
            if (queue_req) begin
                if (!bus.pending) begin
                    bus.pending <= 1'b1;
                    qlen        <= req_len;
                end else begin
                    bus.overflow <= 1'b1;
                end
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_start_level_generator.sv
// Directed and random stimulus for start_level_generator, checked every cycle
// against a timeline model of request start times and lengths.
module tb_start_level_generator;
    import start_gen_pkg::*;

    localparam int CNT_W = 8;
    localparam int HOLD  = 3;
    localparam int GAP_N = 2;

    logic             clk;
    logic             n_rst;
    start_gen_state_t dbg_state;

    start_level_generator_if #(.CNT_W(CNT_W)) bus ();

    start_level_generator #(
        .CNT_W        (CNT_W),
        .HOLD_DEFAULT (HOLD),
        .GAP_CYCLES   (GAP_N)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Timeline model: a sequence started at edge s with length L is high for
    // edges s..s+L-1, low for GAP_N edges, and completes at edge s+L+GAP_N.
    bit m_active = 1'b0;
    int m_s      = 0;
    int m_l      = 0;
    int m_q[$];
    int ecount   = 0;
    int m_starts = 0;
    logic e_sd, e_busy, e_pend, e_done, e_ovf;

    // Rising-edge detector on startData, as the downstream receiver would see it.
    logic sd_prev   = 1'b0;
    int   flag_cnt  = 0;
    int   flag_wide = 0;
    always @(negedge clk) begin
        if (bus.startData === 1'b1 && sd_prev === 1'b1 && !e_sd) flag_wide++;
        if (bus.startData === 1'b1 && sd_prev !== 1'b1) flag_cnt++;
        sd_prev = bus.startData;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit req, input logic [CNT_W-1:0] hold, input bit rst);
        int len;
        len    = (hold == '0) ? HOLD : int'(hold);
        e_done = 1'b0;
        e_ovf  = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_q.delete();
        end else begin
            if (m_active && (ecount == m_s + m_l + GAP_N)) begin
                m_active = 1'b0;
                e_done   = 1'b1;
            end
            if (!m_active && m_q.size() > 0) begin
                m_active = 1'b1;
                m_s      = ecount;
                m_l      = m_q.pop_front();
                m_starts++;
            end
            if (req) begin
                if (!m_active) begin
                    m_active = 1'b1;
                    m_s      = ecount;
                    m_l      = len;
                    m_starts++;
                end else if (m_q.size() == 0) begin
                    m_q.push_back(len);
                end else begin
                    e_ovf = 1'b1;
                end
            end
        end
        e_sd   = m_active && ((ecount - m_s) < m_l);
        e_busy = m_active;
        e_pend = (m_q.size() != 0);
        ecount++;
    endtask

    task automatic cycle(input bit req, input logic [CNT_W-1:0] hold, input bit rst);
        bus.start_req   = req;
        bus.hold_cycles = hold;
        n_rst           = !rst;
        @(posedge clk);
        model_step(req, hold, rst);
        @(negedge clk);
        chk("startData", bus.startData, e_sd);
        chk("busy",      bus.busy,      e_busy);
        chk("pending",   bus.pending,   e_pend);
        chk("done",      bus.done,      e_done);
        chk("overflow",  bus.overflow,  e_ovf);
        chk("state_idle", dbg_state == IDLE, !e_busy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        int budget;
        budget = 600;
        while ((m_active || m_q.size() != 0) && budget > 0) begin
            cycle(1'b0, '0, 1'b0);
            budget--;
        end
        chk_int("drain_budget", (budget > 0) ? 1 : 0, 1);
        cycle(1'b0, '0, 1'b0);
    endtask

    initial begin
        int flags0;
        int starts0;
        int budget;
        bus.start_req   = 1'b0;
        bus.hold_cycles = '0;
        n_rst           = 1'b0;

        // Reset state
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        idle(2);

        // 1 Basic default-length request
        cycle(1'b1, '0, 1'b0);
        idle(8);

        // 2 Explicit length 5
        cycle(1'b1, 8'd5, 1'b0);
        idle(10);

        // 3 Queued second request, length 1, back-to-back after the gap
        cycle(1'b1, '0, 1'b0);
        cycle(1'b1, 8'd1, 1'b0);
        idle(12);

        // 4 Overflow: three requests within one high phase
        cycle(1'b1, 8'd10, 1'b0);
        cycle(1'b1, 8'd2, 1'b0);
        cycle(1'b1, 8'd4, 1'b0);
        drain();

        // 5 Reset mid-high, then a fresh default request
        cycle(1'b1, 8'd6, 1'b0);
        idle(2);
        cycle(1'b1, 8'd2, 1'b0);
        cycle(1'b0, '0, 1'b1);
        idle(1);
        cycle(1'b1, '0, 1'b0);
        idle(8);

        // 6 Four back-to-back requests into the edge detector
        flags0  = flag_cnt;
        starts0 = m_starts;
        for (int r = 0; r < 4; r++) begin
            budget = 100;
            while (m_q.size() != 0 && budget > 0) begin
                cycle(1'b0, '0, 1'b0);
                budget--;
            end
            cycle(1'b1, 8'($urandom_range(1, 4)), 1'b0);
        end
        drain();
        chk_int("loop_flags",  flag_cnt - flags0, 4);
        chk_int("loop_starts", m_starts - starts0, 4);
        chk_int("flag_width",  flag_wide, 0);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            cycle($urandom_range(0, 3) == 0,
                  (r < 3) ? 8'd0 : 8'(r - 2),
                  $urandom_range(0, 149) == 0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
